sbit_frame_tx: RTL and testbench



---
 rtl/sbit_frame_tx.sv | 133 +++++++++++++
 tb/tb_sbit_frame_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sbit_frame_tx.sv
// S-bit frame transmitter: one 64-bit word per frame, 8 bit slots on 8 lines.
// Start-of-frame marks slot 0. Built-in patterns, phase slip, output mask.
//
// Ports:
//   clock, reset_n        bit-slot clock, sync active-low reset
//   data_i, valid_i       word to send and its valid
//   ready_o               word taken on an edge where valid_i & ready_o
//   mode_i                0 data, 1 zero, 2 walking-one, 3 0xAA/0x55
//   mask_i                blank the line outputs, framing keeps running
//   slip_i                request one extra gap slot (phase +1)
//   sbits_o, sof_o        S-bit lines and start-of-frame
//   frames_o, underrun_o  frame counter (wraps), underruns (saturates)
module sbit_frame_tx #(
  parameter int FRAME_CNT_W = 16,
  parameter int UNDERRUN_W  = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [63:0]            data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [1:0]             mode_i,
  input  logic                   mask_i,
  input  logic                   slip_i,
  output logic [7:0]             sbits_o,
  output logic                   sof_o,
  output logic [FRAME_CNT_W-1:0] frames_o,
  output logic [UNDERRUN_W-1:0]  underrun_o
);

  typedef enum logic [3:0] {
    S0  = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3,
    S4  = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7,
    GAP = 4'd8
  } state_t;

  localparam logic [FRAME_CNT_W-1:0] FR_ONE = 1;
  localparam logic [UNDERRUN_W-1:0]  UN_ONE = 1;
  localparam logic [UNDERRUN_W-1:0]  UN_MAX = '1;

  state_t      state;
  state_t      state_n;
  logic [63:0] word;
  logic [63:0] load_word;
  logic        slip_pending;
  logic        mask_q;
  logic [5:0]  idx;
  logic        alt;
  logic        underrun_hit;
  logic        load;
  logic        take_gap;

  logic [FRAME_CNT_W-1:0] frames;
  logic [UNDERRUN_W-1:0]  underrun;

  assign ready_o = reset_n &
    (((state == S7) & ~slip_pending) | (state == GAP));
  assign load     = ready_o;
  assign take_gap = (state == S7) & slip_pending;

  assign frames_o   = frames;
  assign underrun_o = underrun;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= GAP;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      GAP:     state_n = S0;
      S7:      state_n = slip_pending ? GAP : S0;
      default: state_n = state_t'(state + 4'd1);
    endcase
  end

  always_comb begin
    sbits_o = '0;
    sof_o   = 1'b0;
    if (!mask_q && state != GAP) begin
      sbits_o = word[7:0];
      sof_o   = (state == S0);
    end
  end

  always_comb begin
    load_word    = '0;
    underrun_hit = 1'b0;
    unique case (1'b1)
      mode_i == 2'd0: begin
        if (valid_i) load_word = data_i;
        else underrun_hit = 1'b1;
      end
      mode_i == 2'd1: load_word = '0;
      mode_i == 2'd2: load_word = 64'd1 << idx;
      mode_i == 2'd3: load_word = alt ?
        64'h5555_5555_5555_5555 :
        64'hAAAA_AAAA_AAAA_AAAA;
      default: load_word = '0;
    endcase
  end

  // word shifts down a byte per slot so slot k shows word[8k+7:8k]
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      word         <= '0;
      slip_pending <= 1'b0;
      mask_q       <= 1'b0;
      idx          <= '0;
      alt          <= 1'b0;
      frames       <= '0;
      underrun     <= '0;
    end else begin
      mask_q       <= mask_i;
      slip_pending <= slip_i | (slip_pending & ~take_gap);
      if (load) begin
        word   <= load_word;
        frames <= frames + FR_ONE;
        if (underrun_hit && underrun != UN_MAX)
          underrun <= underrun + UN_ONE;
        if (mode_i == 2'd2) idx <= idx + 6'd1;
        if (mode_i == 2'd3) alt <= ~alt;
      end else if (state != GAP) begin
        word <= word >> 8;
      end
    end
  end

endmodule

// File: tb/tb_sbit_frame_tx.sv
// Bench for sbit_frame_tx: slot-plan predictor feeds a per-cycle
// scoreboard, monitor compares on the falling edge.
module tb_sbit_frame_tx;

  logic        clock;
  logic        reset_n;
  logic [63:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  mode_i;
  logic        mask_i;
  logic        slip_i;
  logic [7:0]  sbits_o;
  logic        sof_o;
  logic [15:0] frames_o;
  logic [7:0]  underrun_o;

  sbit_frame_tx #(.FRAME_CNT_W(16), .UNDERRUN_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .mode_i     (mode_i),
    .mask_i     (mask_i),
    .slip_i     (slip_i),
    .sbits_o    (sbits_o),
    .sof_o      (sof_o),
    .frames_o   (frames_o),
    .underrun_o (underrun_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    bit         sof;
    bit         gap;
    bit         last;
  } slot_t;

  typedef struct {
    logic [7:0]  sbits;
    logic        sof;
    logic        rdy;
    logic [15:0] fr;
    logic [7:0]  und;
  } exp_t;

  exp_t  sb[$];
  slot_t plan[$];
  slot_t cur;
  int    m_idx, fr, und;
  bit    m_alt, pend, mq;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Predictor: the DUT is a stream of 8-slot frames; a slip request
  // seen before the last slot of a frame inserts one blank slot after it.
  always @(posedge clock) begin
    logic [63:0] w;
    exp_t e;
    if (!reset_n) begin
      plan.delete();
      cur   = '{b: 8'h00, sof: 0, gap: 1, last: 1};
      m_idx = 0;
      m_alt = 0;
      fr    = 0;
      und   = 0;
      pend  = 0;
      mq    = 0;
    end else begin
      if (cur.last) begin
        w = 64'd0;
        case (mode_i)
          2'd0: if (valid_i) w = data_i;
                else if (und < 255) und++;
          2'd1: w = 64'd0;
          2'd2: begin
            w = 64'd1 << m_idx;
            m_idx = (m_idx + 1) % 64;
          end
          default: begin
            w = m_alt ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
            m_alt = !m_alt;
          end
        endcase
        fr = (fr + 1) % 65536;
        for (int k = 0; k < 8; k++)
          plan.push_back('{b: w[8*k +: 8], sof: (k == 0), gap: 0, last: 0});
        cur  = plan.pop_front();
        pend = pend | slip_i;
      end else if (plan.size() == 0) begin
        cur  = '{b: 8'h00, sof: 0, gap: 1, last: 1};
        pend = slip_i;
      end else begin
        cur  = plan.pop_front();
        pend = pend | slip_i;
      end
      if (!cur.gap && plan.size() == 0) cur.last = !pend;
      mq = mask_i;
    end
    e.sbits = (mq || cur.gap) ? 8'h00 : cur.b;
    e.sof   = !mq && !cur.gap && cur.sof;
    e.rdy   = cur.last;
    e.fr    = fr[15:0];
    e.und   = und[7:0];
    sb.push_back(e);
  end

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sbits", {56'd0, sbits_o}, {56'd0, e.sbits});
      chk("sof", {63'd0, sof_o}, {63'd0, e.sof});
      chk("ready", {63'd0, ready_o}, {63'd0, e.rdy & reset_n});
      chk("frames", {48'd0, frames_o}, {48'd0, e.fr});
      chk("underrun", {56'd0, underrun_o}, {56'd0, e.und});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    data_i  = 64'd0;
    valid_i = 1'b0;
    mode_i  = 2'd0;
    mask_i  = 1'b0;
    slip_i  = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    valid_i = 1'b1;
    data_i  = 64'h0123_4567_89AB_CDEF;
    cyc(24);
    valid_i = 1'b0;
    cyc(24);
    cyc(2400);
    #1;
    chk("underrun_sat", {56'd0, underrun_o}, 64'd255);
    mode_i = 2'd2;
    cyc(66 * 8);
    mode_i = 2'd3;
    cyc(16);
    mode_i  = 2'd0;
    valid_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      data_i = {$urandom, $urandom};
      slip_i = (i == 3);
      cyc(1);
    end
    for (int i = 0; i < 30; i++) begin
      data_i = {$urandom, $urandom};
      slip_i = (i == 2) || (i == 5);
      cyc(1);
    end
    slip_i = 1'b0;
    mask_i = 1'b1;
    cyc(16);
    mask_i = 1'b0;
    cyc(16);
    cyc(4);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(20);
    for (int i = 0; i < 3000; i++) begin
      data_i  = {$urandom, $urandom};
      valid_i = 1'($urandom_range(0, 1));
      mode_i  = 2'($urandom_range(0, 3));
      slip_i  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) mask_i = ~mask_i;
      reset_n = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    reset_n = 1'b1;
    mask_i  = 1'b0;
    slip_i  = 1'b0;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
